lsu_port_arbiter: RTL
=====================

Name: lsu_port_arbiter

Overview:
Shares one LSU RAM port (addr/ce/we/d/q, as presented to the socket's flop bridge) between NUM_REQ requesters, e.g. DMA fill engine and compute kernel.
- Round-robin grant with valid/ready handshake per requester.
- Registered issue onto the RAM port.
- Fixed-latency read-return pipeline that routes port_q back to the requester that issued the read.
- Sits on the compute side of the socket; one instance per LSU port.

Parameters:
- NUM_REQ, 2, number of requesters (2..4).
- ADDR_W, 12, RAM port address width.
- DATA_W, 64, RAM port data width.
- READ_LAT, 2, cycles from port_ce (we=0) on the port to valid port_q (1..4).

Ports:
- clk  in  1  single clock.
- resetn  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of in-flight read tracking and of the RR pointer.
- req_valid  in  NUM_REQ  request present, one bit per requester.
- req_ready  out  NUM_REQ  grant this cycle (one-hot or zero).
- req_we  in  NUM_REQ  1=write, 0=read.
- req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at slice i.
- req_d  in  NUM_REQ*DATA_W  packed write data.
- rsp_valid  out  NUM_REQ  read data valid for requester i.
- rsp_q  out  DATA_W  read data, shared by all requesters.
- port_addr  out  ADDR_W  RAM port address.
- port_ce  out  1  RAM port chip enable.
- port_we  out  1  RAM port write enable.
- port_d  out  DATA_W  RAM port write data.
- port_q  in  DATA_W  RAM port read data.
- idle  out  1  no issue this cycle and no reads in flight.

Behaviour:
- Reset (resetn=0, async):
  - port_ce=0, port_we=0, port_addr=0, port_d=0.
  - rsp_valid=0, read pipeline cleared.
  - RR pointer=0, so requester 0 has top priority.
  - idle=1.
- Arbitration (combinational, same cycle as req_valid):
  - Search starts at RR pointer and wraps modulo NUM_REQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all others get 0.
  - A transfer occurs when req_valid[i] && req_ready[i].
- req_ready does not depend on req_we or req_addr.
- No back-pressure from the RAM: one transfer is accepted every cycle in which any req_valid is high.
- RR pointer update: after a transfer by i, pointer = (i+1) mod NUM_REQ. Unchanged when no transfer.
- Issue (one register stage): on a transfer,
  - next cycle: port_ce=1, port_we=req_we[i], port_addr=req_addr[i], port_d=req_d[i];
  - otherwise port_ce=0, port_we=0, and addr/d hold their last value.
- Read tracking:
  - Shift pipeline of READ_LAT entries {vld, id}.
  - Entry 0 loads {port_ce&~port_we, granted id} in the cycle port_ce is driven.
  - When the tail entry is valid: rsp_valid[id]=1 and rsp_q=port_q in that same cycle (combinational pass-through of port_q). Otherwise rsp_valid=0; rsp_q=port_q, don't-care.
- Latencies:
  - Read: req transfer at cycle T; port_ce at T+1; rsp_valid at T+1+READ_LAT.
  - Write: committed to the RAM at T+1; no response.
- Back-to-back operation: one op per cycle sustained. Any interleaving of reads and writes from different requesters is preserved in order, and responses return in issue order.
- Write-then-read to the same address from different requesters in consecutive cycles returns the new data. Ordering is by port issue order.
- idle = ~port_ce & ~(any pipeline vld) & ~(|req_valid).
- flush=1:
  - Clears pipeline vld bits and the RR pointer to 0 next edge, so no rsp_valid for in-flight reads.
  - Still blocks new grants that cycle: req_ready=0, and port_ce=0 next cycle.
- Reset mid-operation: in-flight reads are discarded and no response is ever produced for them.
- NUM_REQ=1: degenerate case; req_ready[0]=req_valid[0]&~flush.

Decomposition:
- Package lsu_arb_pkg:
  - localparams for default ADDR_W/DATA_W/READ_LAT;
  - function clog2 for the id width;
  - typedef rd_track_t {vld, id}.
- Sub-module rr_arbiter (parameter N): inputs req and ptr; outputs one-hot gnt and gnt_id. Combinational, reused by other socket controllers.
- Top holds the RR pointer, the issue register and the read pipeline.

Test Plan:
- Reset release with all idle -> port_ce=0, rsp_valid=0, idle=1. Requester 0 read of addr 0x010 at T -> port_ce=1/port_we=0/port_addr=0x010 at T+1; rsp_valid=2'b01 with rsp_q=RAM[0x010] at T+3 (READ_LAT=2).
- Both requesters valid continuously with reads for 6 cycles -> grants alternate 0,1,0,1,0,1. rsp_valid tags alternate identically, 3 cycles after each grant.
- Requester 1 writes 0xDEADBEEF_00000001 to 0x0FF at T; requester 0 reads 0x0FF at T+1 -> port_we=1 at T+1, then a read at T+2. rsp_valid[0] at T+4 with rsp_q=0xDEADBEEF_00000001.
- Only requester 1 valid for 3 cycles, then both valid -> pointer is 0 after the last grant to 1, so requester 0 is granted first. No cycle ever has two ready bits set.
- Two reads issued, then resetn=0 for 1 cycle while they are in flight -> no rsp_valid afterwards. All outputs at reset values asynchronously, within the reset cycle.
- Read issued at T, flush=1 at T+2 -> rsp_valid stays 0. req_ready=0 during the flush cycle. Next grant goes to requester 0.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types and defaults for the LSU port arbiter and its round-robin helper.
package lsu_arb_pkg;

    localparam int DEF_ADDR_W   = 12;
    localparam int DEF_DATA_W   = 64;
    localparam int DEF_READ_LAT = 2;
    localparam int MAX_REQ      = 4;
    localparam int TRK_ID_W     = 2;   // wide enough for MAX_REQ requesters

    // Width of an index into n items, never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w = w + 1;
        return w;
    endfunction

    typedef struct packed {
        logic                vld;
        logic [TRK_ID_W-1:0] id;
    } rd_track_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr (wrapping) wins.
module rr_arbiter
    import lsu_arb_pkg::*;
#(
    parameter  int N   = 2,
    localparam int IDW = clog2(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt,
    output logic [IDW-1:0] gnt_id
);

    logic w_found;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && req[j] && (((int'(ptr) + k) % N) == j)) begin
                    w_found = 1'b1;
                    gnt[j]  = 1'b1;
                    gnt_id  = IDW'(j);
                end
            end
        end
    end

endmodule

// File: rtl/lsu_port_arbiter.sv
// Shares one LSU RAM port between NUM_REQ requesters: round-robin grant, registered
// issue, and a fixed-latency tag pipeline that steers port_q back to the reader.
module lsu_port_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int READ_LAT = DEF_READ_LAT
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      flush,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_d,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_q,
    output logic [ADDR_W-1:0]         port_addr,
    output logic                      port_ce,
    output logic                      port_we,
    output logic [DATA_W-1:0]         port_d,
    input  logic [DATA_W-1:0]         port_q,
    output logic                      idle
);

    localparam int ID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_id;
    logic [ID_W-1:0]    w_ptr_nxt;
    logic               w_xfer;
    logic               w_any_vld;
    rd_track_t          w_tail;

    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_issue_id;
    logic               r_port_ce;
    logic               r_port_we;
    logic [ADDR_W-1:0]  r_port_addr;
    logic [DATA_W-1:0]  r_port_d;
    rd_track_t          r_pipe [READ_LAT];

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req    (req_valid),
        .ptr    (r_ptr),
        .gnt    (w_gnt),
        .gnt_id (w_gnt_id)
    );

    // Flush wins over any request: nothing is granted in the flush cycle.
    assign req_ready = flush ? '0 : w_gnt;
    assign w_xfer    = |req_ready;
    assign w_ptr_nxt = (int'(w_gnt_id) == NUM_REQ - 1) ? '0 : w_gnt_id + 1'b1;

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (flush) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_port_ce   <= 1'b0;
            r_port_we   <= 1'b0;
            r_port_addr <= '0;
            r_port_d    <= '0;
            r_issue_id  <= '0;
        end else begin
            r_port_ce <= w_xfer;
            r_port_we <= w_xfer & req_we[w_gnt_id];
            if (w_xfer) begin
                r_port_addr <= req_addr[w_gnt_id*ADDR_W +: ADDR_W];
                r_port_d    <= req_d[w_gnt_id*DATA_W +: DATA_W];
                r_issue_id  <= w_gnt_id;
            end
        end
    end

    // NOTE: the tag pipeline is reset entry by entry; stale vld bits would fabricate responses after reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < READ_LAT; i++) r_pipe[i] <= '0;
        end else begin
            r_pipe[0] <= '{vld: r_port_ce & ~r_port_we & ~flush, id: TRK_ID_W'(r_issue_id)};
            for (int i = 1; i < READ_LAT; i++) begin
                r_pipe[i] <= '{vld: r_pipe[i-1].vld & ~flush, id: r_pipe[i-1].id};
            end
        end
    end

    assign w_tail = r_pipe[READ_LAT-1];

    always_comb begin
        rsp_valid = '0;
        w_any_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_tail.vld && (w_tail.id == TRK_ID_W'(i))) rsp_valid[i] = 1'b1;
        end
        for (int i = 0; i < READ_LAT; i++) begin
            w_any_vld = w_any_vld | r_pipe[i].vld;
        end
    end

    assign rsp_q     = port_q;
    assign port_ce   = r_port_ce;
    assign port_we   = r_port_we;
    assign port_addr = r_port_addr;
    assign port_d    = r_port_d;
    assign idle      = ~r_port_ce & ~w_any_vld & ~(|req_valid);

endmodule
